// File: rtl/alu_seq_pipe.sv
// Sequential ALU with valid/ready on both sides; 1-cycle ops, iterative shift-add MUL (HW+1 cycles).
// Optional flag generation under `ALU_FLAGS_EN`; without it flags read 4'b0000.
module alu_seq_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int HW    = WIDTH / 2;
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(HW) + 1;
  localparam int MSB   = WIDTH - 1;
`ifdef ALU_FLAGS_EN
  localparam int AW = WIDTH + 1;
`else
  localparam int AW = WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand, r_acc, r_r, w_res, w_acc_nxt;
  logic [HW-1:0]    r_mplr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err, w_err, w_accept, w_is_mul, w_mul_last;
  logic [AW-1:0]    w_add, w_sub;
  logic [SH_W-1:0]  w_sh;

  assign w_accept   = in_valid & in_ready;
  assign w_is_mul   = (f == 4'd2);
  assign w_mul_last = (r_state == S_EXEC) && (r_cnt == CNT_W'(1));
  assign w_add      = AW'(a) + AW'(b);
  assign w_sub      = AW'(a) - AW'(b);
  assign w_sh       = b[SH_W-1:0];
  assign w_acc_nxt  = r_acc + (r_mplr[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_EXEC : S_DONE;
      S_EXEC: if (w_mul_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = !w_accept ? S_IDLE : (w_is_mul ? S_EXEC : S_DONE);
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // DONE passes out_ready straight to in_ready so a taken result can overlap the next accept.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (f)
      4'd0: w_res = w_add[MSB:0];
      4'd1: w_res = w_sub[MSB:0];
      4'd3: w_res = a & b;
      4'd4: w_res = a | b;
      4'd5: w_res = ~a;
      4'd6: w_res = a ^ b;
      4'd7: w_res = a << w_sh;
      4'd8: w_res = a >> w_sh;
      4'd9: w_res = $signed(a) >>> w_sh;
      4'd2: w_res = '0;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_r     <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept && w_is_mul) begin
        r_mcand <= {{(WIDTH-HW){1'b0}}, a[HW-1:0]};
        r_mplr  <= b[HW-1:0];
        r_acc   <= '0;
        r_cnt   <= CNT_W'(HW);
      end else if (r_state == S_EXEC) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_cnt   <= r_cnt - CNT_W'(1);
      end
      if (w_accept && !w_is_mul) begin
        r_r   <= w_res;
        r_err <= w_err;
      end else if (w_mul_last) begin
        r_r   <= w_acc_nxt;
        r_err <= 1'b0;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic [3:0] r_flags;
  logic       w_c, w_v;

  always_comb begin
    w_c = 1'b0;
    w_v = 1'b0;
    if (f == 4'd0) begin
      w_c = w_add[WIDTH];
      w_v = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
    end else if (f == 4'd1) begin
      w_c = w_sub[WIDTH];
      w_v = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_flags <= 4'b0000;
    else if (w_accept && !w_is_mul) r_flags <= {w_res[MSB], ~|w_res, w_c, w_v};
    else if (w_mul_last)           r_flags <= {w_acc_nxt[MSB], ~|w_acc_nxt, 2'b00};
  end

  assign flags = r_flags;
`else
  assign flags = 4'b0000;
`endif

  assign r   = r_r;
  assign err = r_err;

endmodule

// File: tb/tb_alu_seq_pipe.sv
// Scoreboard bench for alu_seq_pipe: directed spec cases, backpressure, reset mid-MUL, random ops.
module tb_alu_seq_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  f = '0;
  logic        in_ready, out_valid, err;
  logic [31:0] r;
  logic [3:0]  flags;

  alu_seq_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

`ifdef ALU_FLAGS_EN
  localparam logic [3:0] FLMASK = 4'hF;
`else
  localparam logic [3:0] FLMASK = 4'h0;
`endif
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  typedef struct packed {logic [31:0] r; logic [3:0] fl; logic e;} res_t;
  res_t sb_q[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    res_t            o;
    longint unsigned ux = x, uy = y, t;
    longint          sx = $signed(x), sy = $signed(y), s;
    int              sh = int'(y & 32'h1F);
    logic            c = 1'b0, v = 1'b0;
    o = '0;
    case (op)
      4'd0: begin t = ux + uy; o.r = t[31:0]; c = (t >> 32) != 0; s = sx + sy; v = (s > MAXS) || (s < MINS); end
      4'd1: begin o.r = x - y; c = ux < uy; s = sx - sy; v = (s > MAXS) || (s < MINS); end
      4'd2: o.r = 32'((ux % 65536) * (uy % 65536));
      4'd3: o.r = x & y;
      4'd4: o.r = x | y;
      4'd5: o.r = ~x;
      4'd6: o.r = x ^ y;
      4'd7: o.r = 32'(ux << sh);
      4'd8: o.r = 32'(ux / (64'd1 << sh));
      4'd9: o.r = (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      default: o.e = 1'b1;
    endcase
    o.fl = {o.r[31], o.r == 32'h0, c, v} & FLMASK;
    return o;
  endfunction

  // Monitor: pops on every handshake and checks that a stalled result never changes.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_r = '0;
    res_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_r", r, prev_r);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got r=%0h with empty scoreboard", r);
        end else begin
          e = sb_q.pop_front();
          chk("sb_r", r, e.r);
          chk("sb_flags", flags, e.fl);
          chk("sb_err", err, e.e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = r;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb, input bit rnd);
    bit acc = 1'b0;
    int n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = 1'b1;
      f = op; a = xa; b = xb;
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) sb_q.push_back(model(op, xa, xb));
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", n);
    end
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  endtask

  task automatic wait_out(input int exp_lat, input int exp_busy, input string nm);
    int n = 0, busy = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      n++;
      if (out_valid) seen = 1'b1;
      else if (!in_ready) busy++;
    end
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_busy"}, busy, exp_busy);
  endtask

  initial begin
    logic [31:0] r0, xa, xb;
    logic [3:0]  op;
    logic [31:0] corner [4];
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_r", r, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    issue(4'd0, 32'd7, 32'd4, 0);               wait_out(1, 0, "add");  chk("add_r", r, 32'd11);
    issue(4'd1, 32'd4, 32'd7, 0);               wait_out(1, 0, "sub");  chk("sub_r", r, 32'hFFFF_FFFD);
    issue(4'd2, 32'd7, 32'd4, 0);               wait_out(17, 16, "mul"); chk("mul_r", r, 32'd28);
    issue(4'd2, 32'h0001_FFFF, 32'h0001_FFFF, 0); wait_out(17, 16, "mulhi"); chk("mulhi_r", r, 32'hFFFE_0001);
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 0);       wait_out(1, 0, "addov"); chk("addov_r", r, 32'h8000_0000);
    issue(4'd9, 32'h8000_0000, 32'h21, 0);      wait_out(1, 0, "sra");  chk("sra_r", r, 32'hC000_0000);
    issue(4'd15, 32'h1234, 32'h5678, 0);        wait_out(1, 0, "ill");  chk("ill_err", err, 1);

    // Backpressure on an XOR, then take it and accept an AND in the same cycle.
    issue(4'd6, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("bp_valid", out_valid, 1);
    r0 = r;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); out_ready = 1'b0; #1; end
      chk("bp_r_stable", r, r0);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; f = 4'd3; a = 32'hF0F0_1234; b = 32'h0FF0_FF00;
    #1;
    chk("bp_overlap_ready", in_ready, 1);
    @(posedge clk);
    sb_q.push_back(model(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_no_gap", out_valid, 1);
    chk("bp_and_r", r, 32'h00F0_1200);

    // Reset in the middle of a multiply.
    idle(2, 0);
    issue(4'd2, 32'h0000_0123, 32'h0000_0456, 0);
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_mul_busy", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_r", r, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 32'd1, 32'd1, 0); wait_out(1, 0, "post_rst"); chk("post_rst_r", r, 32'd2);

    // Random ops with random backpressure and gaps.
    for (int k = 0; k < 400; k++) begin
      op = 4'($urandom_range(0, 15));
      xa = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      xb = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      issue(op, xa, xb, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1);
    end
    idle(40, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
